sum_block_accum: RTL and testbench

Downstream consumer of the 8-bit adder stage. It accepts a stream of adder results over a valid/ready handshake and groups them into blocks of BLOCK samples. For each block it produces the 16-bit total and the maximum sample, handed to the next stage over a second valid/ready handshake. While a result is pending, the input is stalled.

---
 rtl/sum_block_accum_if.sv | 23 ++
 rtl/sum_block_accum.sv | 83 ++++++++
 tb/tb_sum_block_accum.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sum_block_accum_if.sv
// Handshake bundle for sum_block_accum: sample stream in, block result out.
// The master side is the producer/consumer pair around the accumulator.
interface sum_block_accum_if;
    logic [7:0]  sum_in;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic [15:0] total;
    logic [7:0]  max;
    logic [7:0]  count;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output sum_in, in_valid, clear, out_ready,
        input  in_ready, total, max, count, out_valid
    );

    modport slave (
        input  sum_in, in_valid, clear, out_ready,
        output in_ready, total, max, count, out_valid
    );
endinterface

// File: rtl/sum_block_accum.sv
// Groups adder results into blocks of BLOCK samples and reports each block's
// 16-bit total and maximum sample; the input stalls while a result is pending.
module sum_block_accum #(
    parameter int BLOCK = 4
) (
    input  logic              clock,
    input  logic              reset,
    sum_block_accum_if.slave  bus
);

    if (BLOCK < 1 || BLOCK > 255) begin : g_bad_block
        $error("sum_block_accum: BLOCK must be in 1..255");
    end

    localparam logic [7:0] LAST = 8'(BLOCK - 1);

    typedef enum logic {ACC, DONE} state_t;

    state_t      state;
    logic [15:0] acc;
    logic [7:0]  mx;
    logic [7:0]  cnt;
    logic [15:0] total_q;
    logic [7:0]  max_q;

    logic [15:0] acc_nxt;
    logic [7:0]  mx_nxt;
    logic        accept;

    // Sum cannot overflow 16 bits: at most 255 samples of 255 each.
    assign acc_nxt = acc + {8'h00, bus.sum_in};
    assign mx_nxt  = (bus.sum_in > mx) ? bus.sum_in : mx;
    assign accept  = (state == ACC) && bus.in_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ACC;
            acc     <= '0;
            mx      <= '0;
            cnt     <= '0;
            total_q <= '0;
            max_q   <= '0;
        end else if (bus.clear) begin
            // Drops the partial block and any pending result; outputs keep last values.
            state <= ACC;
            acc   <= '0;
            mx    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            total_q <= acc_nxt;
                            max_q   <= mx_nxt;
                            acc     <= '0;
                            mx      <= '0;
                            cnt     <= '0;
                            state   <= DONE;
                        end else begin
                            acc <= acc_nxt;
                            mx  <= mx_nxt;
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == DONE);
    assign bus.total     = total_q;
    assign bus.max       = max_q;
    assign bus.count     = cnt;

endmodule

// File: tb/tb_sum_block_accum.sv
// Directed bench: BLOCK=4 and BLOCK=1 instances, results checked by a
// scoreboard monitor, handshake/count behaviour checked inline.
module tb_sum_block_accum;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    sum_block_accum_if a ();
    sum_block_accum_if b ();

    sum_block_accum #(.BLOCK(4)) dut4 (.clock(clock), .reset(rst_n), .bus(a));
    sum_block_accum #(.BLOCK(1)) dut1 (.clock(clock), .reset(rst_n), .bus(b));

    int errors = 0;
    int checks = 0;

    logic [23:0] sba[$];
    logic [23:0] sbb[$];
    logic a_vld_q = 1'b0;
    logic b_vld_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_a(input logic [7:0] v);
        chk("a_in_ready_before_send", 32'(a.in_ready), 32'd1);
        a.sum_in   = v;
        a.in_valid = 1'b1;
        step();
        a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] v);
        chk("b_in_ready_before_send", 32'(b.in_ready), 32'd1);
        b.sum_in   = v;
        b.in_valid = 1'b1;
        step();
        b.in_valid = 1'b0;
    endtask

    // Result monitors: check each newly presented result against the scoreboard.
    always @(negedge clock) begin
        if (rst_n && a.out_valid && !a_vld_q) begin
            if (sba.size() == 0) begin
                chk("a_unexpected_result", 32'(a.out_valid), 32'd0);
            end else begin
                logic [23:0] e;
                e = sba.pop_front();
                chk("a_total", 32'(a.total), 32'(e[23:8]));
                chk("a_max", 32'(a.max), 32'(e[7:0]));
            end
        end
        a_vld_q = a.out_valid;
    end

    always @(negedge clock) begin
        if (rst_n && b.out_valid && !b_vld_q) begin
            if (sbb.size() == 0) begin
                chk("b_unexpected_result", 32'(b.out_valid), 32'd0);
            end else begin
                logic [23:0] e;
                e = sbb.pop_front();
                chk("b_total", 32'(b.total), 32'(e[23:8]));
                chk("b_max", 32'(b.max), 32'(e[7:0]));
            end
        end
        b_vld_q = b.out_valid;
    end

    initial begin
        a.sum_in = 8'h00; a.in_valid = 1'b0; a.clear = 1'b0; a.out_ready = 1'b1;
        b.sum_in = 8'h00; b.in_valid = 1'b0; b.clear = 1'b0; b.out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_in_ready", 32'(a.in_ready), 32'd1);
        chk("rst_out_valid", 32'(a.out_valid), 32'd0);
        chk("rst_total", 32'(a.total), 32'h0);
        chk("rst_max", 32'(a.max), 32'h0);
        chk("rst_count", 32'(a.count), 32'h0);

        // Mixed block, back-to-back
        sba.push_back({16'h0244, 8'hFF});
        send_a(8'h00); chk("t1_count1", 32'(a.count), 32'd1);
        send_a(8'hFF); chk("t1_count2", 32'(a.count), 32'd2);
        send_a(8'hC4); chk("t1_count3", 32'(a.count), 32'd3);
        send_a(8'h81);
        chk("t1_done_count", 32'(a.count), 32'd0);
        chk("t1_done_in_ready", 32'(a.in_ready), 32'd0);
        chk("t1_done_out_valid", 32'(a.out_valid), 32'd1);
        step();
        chk("t1_back_in_ready", 32'(a.in_ready), 32'd1);
        chk("t1_back_out_valid", 32'(a.out_valid), 32'd0);

        // All-max block, then a block with idle gaps
        sba.push_back({16'h03FC, 8'hFF});
        for (int i = 0; i < 4; i++) send_a(8'hFF);
        step();
        sba.push_back({16'h0066, 8'h63});
        send_a(8'h63); step(); step();
        chk("t2_gap_count", 32'(a.count), 32'd1);
        send_a(8'h00); step(); step();
        send_a(8'h01); step(); step();
        chk("t2_gap_count3", 32'(a.count), 32'd3);
        send_a(8'h02);
        step();

        // Backpressure
        sba.push_back({16'h0040, 8'h10});
        a.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_a(8'h10);
        a.sum_in = 8'h11; a.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", 32'(a.out_valid), 32'd1);
            chk("bp_total", 32'(a.total), 32'h0040);
            chk("bp_max", 32'(a.max), 32'h10);
            chk("bp_in_ready", 32'(a.in_ready), 32'd0);
            chk("bp_count", 32'(a.count), 32'd0);
        end
        a.out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", 32'(a.in_ready), 32'd1);
        chk("bp_release_count", 32'(a.count), 32'd0);
        step();
        chk("bp_accept_count", 32'(a.count), 32'd1);
        a.in_valid = 1'b0;
        sba.push_back({16'h0044, 8'h11});
        for (int i = 0; i < 3; i++) send_a(8'h11);
        step();

        // Reset mid-block
        send_a(8'h10); send_a(8'h20);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mid_rst_count", 32'(a.count), 32'd0);
        chk("mid_rst_total", 32'(a.total), 32'h0);
        chk("mid_rst_max", 32'(a.max), 32'h0);
        chk("mid_rst_out_valid", 32'(a.out_valid), 32'd0);
        sba.push_back({16'h0004, 8'h01});
        for (int i = 0; i < 4; i++) send_a(8'h01);
        step();

        // Clear drops the partial block and a simultaneous sample
        send_a(8'h80); send_a(8'h80);
        a.clear = 1'b1; a.sum_in = 8'h05; a.in_valid = 1'b1;
        step();
        a.clear = 1'b0; a.in_valid = 1'b0;
        chk("clr_count", 32'(a.count), 32'd0);
        chk("clr_total", 32'(a.total), 32'h0004);
        chk("clr_max", 32'(a.max), 32'h01);
        sba.push_back({16'h000A, 8'h04});
        a.out_ready = 1'b0;
        send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04);
        chk("clr_done_out_valid", 32'(a.out_valid), 32'd1);
        a.clear = 1'b1;
        step();
        a.clear = 1'b0; a.out_ready = 1'b1;
        chk("clr_in_done_out_valid", 32'(a.out_valid), 32'd0);
        chk("clr_in_done_in_ready", 32'(a.in_ready), 32'd1);
        chk("clr_in_done_total", 32'(a.total), 32'h000A);

        // BLOCK=1 instance
        sbb.push_back({16'h0042, 8'h42});
        sbb.push_back({16'h0021, 8'h21});
        send_b(8'h42);
        chk("b1_in_ready0", 32'(b.in_ready), 32'd0);
        step();
        chk("b1_in_ready1", 32'(b.in_ready), 32'd1);
        send_b(8'h21);
        chk("b1_in_ready2", 32'(b.in_ready), 32'd0);
        step();
        chk("b1_in_ready3", 32'(b.in_ready), 32'd1);

        step(); step();
        chk("a_scoreboard_drained", 32'(sba.size()), 32'd0);
        chk("b_scoreboard_drained", 32'(sbb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
